// File: rtl/vga_bar_pkg.sv
// Shared timing defaults, colour type and colour constants
// for the bar-graph VGA display.
package vga_bar_pkg;

   typedef logic [11:0] rgb_t;

   localparam int H_ACTIVE_D     = 800;
   localparam int H_SYNC_START_D = 856;
   localparam int H_SYNC_END_D   = 976;
   localparam int H_TOTAL_D      = 1040;
   localparam int V_ACTIVE_D     = 600;
   localparam int V_SYNC_START_D = 637;
   localparam int V_SYNC_END_D   = 643;
   localparam int V_TOTAL_D      = 666;

   localparam rgb_t BAR_COLOR_D = 12'h0F0;
   localparam rgb_t SEL_COLOR_D = 12'hF00;
   localparam rgb_t BLACK       = 12'h000;

   function automatic int sat_step(int h, int step, bit up, int hi);
      int r;
      r = up ? h + step : h - step;
      if (r > hi) r = hi;
      if (r < 0) r = 0;
      return r;
   endfunction

endpackage

// File: rtl/vga_bar_graph_if.sv
// Button inputs and VGA outputs of the bar-graph display.
interface vga_bar_graph_if;
   logic       incr;
   logic       decr;
   logic       mvUp;
   logic       mvDown;
   logic       hsync;
   logic       vsync;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;

   modport master (
      output incr, decr, mvUp, mvDown,
      input  hsync, vsync, red, green, blue
   );

   modport slave (
      input  incr, decr, mvUp, mvDown,
      output hsync, vsync, red, green, blue
   );
endinterface

// File: rtl/vga_timing.sv
// Pixel enable, raster counters and registered sync pulses.
module vga_timing
   import vga_bar_pkg::*;
#(
   parameter int H_ACTIVE     = H_ACTIVE_D,
   parameter int H_SYNC_START = H_SYNC_START_D,
   parameter int H_SYNC_END   = H_SYNC_END_D,
   parameter int H_TOTAL      = H_TOTAL_D,
   parameter int V_ACTIVE     = V_ACTIVE_D,
   parameter int V_SYNC_START = V_SYNC_START_D,
   parameter int V_SYNC_END   = V_SYNC_END_D,
   parameter int V_TOTAL      = V_TOTAL_D,
   parameter int HW           = $clog2(H_TOTAL),
   parameter int VW           = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pix_en,
   output logic [HW-1:0] hor,
   output logic [VW-1:0] ver,
   output logic          active,
   output logic          frame_start,
   output logic          hsync,
   output logic          vsync
);

   logic h_last;
   logic v_last;

   assign h_last      = (int'(hor) == H_TOTAL - 1);
   assign v_last      = (int'(ver) == V_TOTAL - 1);
   assign active      = (int'(hor) < H_ACTIVE) && (int'(ver) < V_ACTIVE);
   assign frame_start = pix_en && (hor == '0) && (int'(ver) == V_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_en <= 1'b1;
         hor    <= '0;
         ver    <= '0;
         hsync  <= 1'b1;
         vsync  <= 1'b1;
      end else begin
         pix_en <= ~pix_en;
         if (pix_en) begin
            hsync <= !((int'(hor) >= H_SYNC_START) && (int'(hor) < H_SYNC_END));
            vsync <= !((int'(ver) >= V_SYNC_START) && (int'(ver) < V_SYNC_END));
            if (h_last) begin
               hor <= '0;
               ver <= v_last ? '0 : ver + VW'(1);
            end else begin
               hor <= hor + HW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/vga_bar_graph.sv
// Button-controlled vertical bar graph on a VGA raster,
// with per-frame shadow copies of the selection and heights.
module vga_bar_graph
   import vga_bar_pkg::*;
#(
   parameter int   NUM_BARS     = 3,
   parameter int   H_ACTIVE     = H_ACTIVE_D,
   parameter int   H_SYNC_START = H_SYNC_START_D,
   parameter int   H_SYNC_END   = H_SYNC_END_D,
   parameter int   H_TOTAL      = H_TOTAL_D,
   parameter int   V_ACTIVE     = V_ACTIVE_D,
   parameter int   V_SYNC_START = V_SYNC_START_D,
   parameter int   V_SYNC_END   = V_SYNC_END_D,
   parameter int   V_TOTAL      = V_TOTAL_D,
   parameter int   HEIGHT_STEP  = 20,
   parameter rgb_t BAR_COLOR    = BAR_COLOR_D,
   parameter rgb_t SEL_COLOR    = SEL_COLOR_D
) (
   input logic            clk,
   input logic            rst,
   vga_bar_graph_if.slave bus
);

   localparam int HW    = $clog2(H_TOTAL);
   localparam int VW    = $clog2(V_TOTAL);
   localparam int SW    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam int BAR_W = H_ACTIVE / NUM_BARS;
   localparam int HALF  = V_ACTIVE / 2;

   logic          pix_en;
   logic          active;
   logic          frame_start;
   logic [HW-1:0] hor;
   logic [VW-1:0] ver;

   vga_timing #(
      .H_ACTIVE     (H_ACTIVE),
      .H_SYNC_START (H_SYNC_START),
      .H_SYNC_END   (H_SYNC_END),
      .H_TOTAL      (H_TOTAL),
      .V_ACTIVE     (V_ACTIVE),
      .V_SYNC_START (V_SYNC_START),
      .V_SYNC_END   (V_SYNC_END),
      .V_TOTAL      (V_TOTAL),
      .HW           (HW),
      .VW           (VW)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .hor         (hor),
      .ver         (ver),
      .active      (active),
      .frame_start (frame_start),
      .hsync       (bus.hsync),
      .vsync       (bus.vsync)
   );

   // bit order {mvDown, mvUp, decr, incr}
   logic [3:0] btn;
   logic [3:0] s1;
   logic [3:0] s2;
   logic [3:0] s3;
   logic [3:0] pulse;
   logic [1:0] warm;

   assign btn = {bus.mvDown, bus.mvUp, bus.decr, bus.incr};

   // Pulses stay masked until the synchroniser has refilled after
   // reset, so a button held across reset release is not a press.
   assign pulse = (warm == 2'd3) ? (s2 & ~s3) : 4'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         s3   <= '0;
         warm <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         s3 <= s2;
         if (warm != 2'd3) warm <= warm + 2'd1;
      end
   end

   logic [SW-1:0] sel_w;
   logic [SW-1:0] sel_d;
   logic [SW-1:0] sel_nx;
   logic [VW-1:0] height_w [NUM_BARS];
   logic [VW-1:0] height_d [NUM_BARS];

   always_comb begin
      sel_nx = sel_w;
      unique case ({pulse[3], pulse[2]})
         2'b01:   sel_nx = (int'(sel_w) == NUM_BARS - 1) ? '0 : sel_w + SW'(1);
         2'b10:   sel_nx = (sel_w == '0) ? SW'(NUM_BARS - 1) : sel_w - SW'(1);
         default: sel_nx = sel_w;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_w <= '0;
         sel_d <= '0;
         for (int i = 0; i < NUM_BARS; i++) begin
            height_w[i] <= VW'(HALF);
            height_d[i] <= VW'(HALF);
         end
      end else begin
         sel_w <= sel_nx;
         if (pulse[0] ^ pulse[1])
            height_w[sel_w] <= VW'(sat_step(int'(height_w[sel_w]),
                                            HEIGHT_STEP, pulse[0], V_ACTIVE));
         if (frame_start) begin
            sel_d    <= sel_w;
            height_d <= height_w;
         end
      end
   end

   rgb_t pix_nx;
   rgb_t rgb;

   always_comb begin
      pix_nx = BLACK;
      if (active) begin
         for (int i = 0; i < NUM_BARS; i++) begin
            if ((int'(hor) >= i * BAR_W) && (int'(hor) < (i + 1) * BAR_W) &&
                (int'(ver) >= V_ACTIVE - int'(height_d[i])))
               pix_nx = (SW'(i) == sel_d) ? SEL_COLOR : BAR_COLOR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         rgb <= BLACK;
      else if (pix_en) rgb <= pix_nx;
   end

   assign bus.red   = rgb[11:8];
   assign bus.green = rgb[7:4];
   assign bus.blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_bar_graph.sv
// Scoreboard bench: default-timing instance for sync and button
// state, a small-raster 5-bar instance for pixel colours.
module tb_vga_bar_graph;
   import vga_bar_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_bar_graph_if a_if ();
   vga_bar_graph_if b_if ();

   vga_bar_graph dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   vga_bar_graph #(
      .NUM_BARS     (5),
      .H_ACTIVE     (40),
      .H_SYNC_START (44),
      .H_SYNC_END   (50),
      .H_TOTAL      (56),
      .V_ACTIVE     (30),
      .V_SYNC_START (32),
      .V_SYNC_END   (34),
      .V_TOTAL      (36),
      .HEIGHT_STEP  (4)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   typedef struct {
      string name;
      int    kind;
      int    n;
      int    exp;
   } item_t;

   item_t st_q[$];
   item_t sy_q[$];
   item_t px_q[$];

   int   total = 0;
   int   bad = 0;
   int   ncyc = 0;
   bit   timed_out = 1'b0;
   logic hs_prev = 1'b1;
   int   last_fall = 0;
   int   falls = 0;

   always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

   function automatic void add_st(string nm, int k, int e);
      st_q.push_back('{nm, k, 0, e});
   endfunction

   function automatic void add_sy(string nm, int e);
      sy_q.push_back('{nm, 0, 0, e});
   endfunction

   // small raster: 56 pixels per line, 2016 pixels per frame
   function automatic void add_px(string nm, int f, int h, int v, int e);
      px_q.push_back('{nm, 0, f * 2016 + v * 56 + h, e});
   endfunction

   function automatic int state_act(int k);
      case (k)
         0:       return int'(dut_a.sel_w);
         1:       return int'(dut_a.height_w[0]);
         3:       return int'(dut_a.sel_d);
         4:       return int'(dut_a.height_d[0]);
         default: return int'({a_if.hsync, a_if.vsync,
                                a_if.red, a_if.green, a_if.blue});
      endcase
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      item_t it;
      while (st_q.size() > 0) begin
         it = st_q.pop_front();
         chk(it.name, state_act(it.kind), it.exp);
      end
      if (!rst && sy_q.size() > 0) begin
         if (hs_prev && !a_if.hsync) begin
            it = sy_q.pop_front();
            chk(it.name, (falls == 0) ? ncyc : ncyc - last_fall, it.exp);
            last_fall = ncyc;
            falls++;
         end else if (!hs_prev && a_if.hsync) begin
            it = sy_q.pop_front();
            chk(it.name, ncyc - last_fall, it.exp);
         end
      end
      hs_prev = a_if.hsync;
      if (!rst && ncyc[0] && px_q.size() > 0 && px_q[0].n == (ncyc - 1) / 2) begin
         it = px_q.pop_front();
         chk(it.name, int'({b_if.red, b_if.green, b_if.blue}), it.exp);
      end
      if (timed_out) begin
         while (sy_q.size() > 0) begin
            it = sy_q.pop_front();
            chk({it.name, "_timeout"}, -1, it.exp);
         end
         while (px_q.size() > 0) begin
            it = px_q.pop_front();
            chk({it.name, "_timeout"}, -1, it.exp);
         end
      end
   end

   task automatic press(input bit to_b, input logic [3:0] m);
      if (to_b) {b_if.mvDown, b_if.mvUp, b_if.decr, b_if.incr} = m;
      else      {a_if.mvDown, a_if.mvUp, a_if.decr, a_if.incr} = m;
      repeat (6) @(negedge clk);
      {a_if.mvDown, a_if.mvUp, a_if.decr, a_if.incr} = 4'b0;
      {b_if.mvDown, b_if.mvUp, b_if.decr, b_if.incr} = 4'b0;
      repeat (4) @(negedge clk);
   endtask

   localparam logic [3:0] INC  = 4'b0001;
   localparam logic [3:0] DEC  = 4'b0010;
   localparam logic [3:0] UP   = 4'b0100;
   localparam logic [3:0] DOWN = 4'b1000;

   initial begin
      {a_if.mvDown, a_if.mvUp, a_if.decr, a_if.incr} = UP;
      {b_if.mvDown, b_if.mvUp, b_if.decr, b_if.incr} = 4'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      add_st("reset_outputs", 2, 'h3000);
      add_sy("first_hsync_fall", 1713);
      add_sy("hsync_low_width", 240);
      add_sy("line_period", 2080);
      add_px("f0_b0_v11", 0, 3, 11, 'h000);
      add_px("f0_b0_v14", 0, 3, 14, 'h000);
      add_px("f0_b0_v15", 0, 3, 15, 'hF00);
      add_px("f0_b4_v20", 0, 39, 20, 'h0F0);
      add_px("f0_blank_h41", 0, 41, 20, 'h000);
      add_px("f0_b0_v29", 0, 3, 29, 'hF00);
      add_px("f0_b1_v29", 0, 9, 29, 'h0F0);
      add_px("f0_vblank", 0, 3, 31, 'h000);
      add_px("f1_b0_v10", 1, 3, 10, 'h000);
      add_px("f1_b0_v11", 1, 3, 11, 'h0F0);
      add_px("f1_b2_v14", 1, 17, 14, 'h000);
      add_px("f1_h7_v15", 1, 7, 15, 'h0F0);
      add_px("f1_h8_v15", 1, 8, 15, 'hF00);
      add_px("f1_b1_v15", 1, 9, 15, 'hF00);
      add_px("f1_b2_v15", 1, 17, 15, 'h0F0);
      add_px("f1_b1_v29", 1, 9, 29, 'hF00);
      rst = 1'b0;

      repeat (10) @(negedge clk);
      add_st("held_mvup_no_pulse", 0, 0);
      a_if.mvUp = 1'b0;
      repeat (4) @(negedge clk);

      while (ncyc < 600) @(negedge clk);
      press(1'b1, INC);
      press(1'b1, UP);

      press(1'b0, UP);         add_st("sel_up1", 0, 1);
      press(1'b0, UP);         add_st("sel_up2", 0, 2);
      press(1'b0, UP);         add_st("sel_up_wrap", 0, 0);
      press(1'b0, DOWN);       add_st("sel_down_wrap", 0, 2);
      press(1'b0, UP | DOWN);  add_st("sel_both", 0, 2);
      press(1'b0, UP);         add_st("sel_back0", 0, 0);
      for (int i = 0; i < 16; i++) press(1'b0, INC);
      add_st("h0_sat_top", 1, 600);
      press(1'b0, DEC);        add_st("h0_dec1", 1, 580);
      press(1'b0, INC | DEC);  add_st("h0_both", 1, 580);
      for (int i = 0; i < 30; i++) press(1'b0, DEC);
      add_st("h0_sat_zero", 1, 0);
      press(1'b0, INC | UP);
      add_st("h0_old_sel", 1, 20);
      add_st("sel_with_incr", 0, 1);
      add_st("sel_d_held", 3, 0);
      add_st("height_d_held", 4, 300);

      while ((st_q.size() + sy_q.size() + px_q.size()) > 0 && ncyc < 12000)
         @(negedge clk);
      if ((sy_q.size() + px_q.size()) > 0) timed_out = 1'b1;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
